// File: rtl/mem_resp_if.sv
// mem_resp_if -- request/response bus between an initiator and mem_resp.
//
// Signals
//   req    initiator request strobe, held until ready is seen
//   we     1 = write, 0 = read (sampled with req)
//   addr   32-bit byte address
//   wdata  32-bit write data (sampled with req)
//   rdata  32-bit response data, meaningful only while ready = 1
//   ready  one-cycle response pulse ending the transaction
//   err    misaligned-access flag, meaningful only while ready = 1
//
// Modports: master (initiator side), slave (mem_resp side).
interface mem_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_resp.sv
// mem_resp -- single-port word memory with a fixed-latency request/response
// handshake.  An access is captured in IDLE, waits LATENCY cycles in WAIT and
// completes with a one-cycle ready pulse in RESP (LATENCY+1 cycles after the
// capture cycle).  Writes commit on the RESP clock edge and echo wdata.
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit words (word index = addr[DEPTH_LOG2+1:2])
//   LATENCY     wait cycles between capture and response, 0..15
//
// Ports
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   mem_resp_if.slave (req/we/addr/wdata in, rdata/ready/err out)
//
// Optional feature
//   MEM_RESP_ALIGN_CHK_EN  when defined, a captured address with addr[1:0] != 0
//                          responds with err = 1, rdata = 0 and no write.
//                          When undefined, addr[1:0] is ignored and err = 0.
module mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    we_reg, we_next;
  logic [DEPTH_LOG2-1:0]   addr_idx_reg, addr_idx_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic                    misaligned;

  // Storage: no reset, registered read so it maps onto block RAM.
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rd_data_reg;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    commit;

`ifdef MEM_RESP_ALIGN_CHK_EN
  logic [1:0]              addr_lo_reg, addr_lo_next;
  assign misaligned = |addr_lo_reg;
`else
  assign misaligned = 1'b0;
`endif

  // State and captured request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      we_reg       <= 1'b0;
      addr_idx_reg <= '0;
      wdata_reg    <= '0;
`ifdef MEM_RESP_ALIGN_CHK_EN
      addr_lo_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      addr_idx_reg <= addr_idx_next;
      wdata_reg    <= wdata_next;
`ifdef MEM_RESP_ALIGN_CHK_EN
      addr_lo_reg  <= addr_lo_next;
`endif
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    addr_idx_next = addr_idx_reg;
    wdata_next    = wdata_reg;
`ifdef MEM_RESP_ALIGN_CHK_EN
    addr_lo_next  = addr_lo_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          we_next       = bus.we;
          addr_idx_next = bus.addr[DEPTH_LOG2+1:2];
          wdata_next    = bus.wdata;
`ifdef MEM_RESP_ALIGN_CHK_EN
          addr_lo_next  = bus.addr[1:0];
`endif
          if (LATENCY == 0) begin
            state_next = RESP;
            cnt_next   = '0;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        // The cycle spent at zero is still a wait cycle, giving LATENCY of them.
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In IDLE the RAM is addressed straight from the bus so that a LATENCY = 0
  // access already has its read data registered when it enters RESP; in all
  // other states it follows the captured index.
  assign rd_idx = (state_reg == IDLE) ? bus.addr[DEPTH_LOG2+1:2] : addr_idx_reg;

  // A reset arriving mid-transaction returns state to IDLE before the RESP
  // edge, so an uncommitted write can never reach storage.
  assign commit = (state_reg == RESP) && we_reg && !misaligned && !rst;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[addr_idx_reg] <= wdata_reg;
    end
    rd_data_reg <= mem[rd_idx];
  end

  // Outputs are decoded from the (asynchronously reset) state, so they drop
  // to zero the instant rst rises.
  always_comb begin
    bus.ready = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = '0;
    if (state_reg == RESP) begin
      bus.ready = 1'b1;
      bus.err   = misaligned;
      if (!misaligned) begin
        bus.rdata = we_reg ? wdata_reg : rd_data_reg;
      end
    end
  end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of the word count of internal storage (1024 x 32-bit).
REQ-002 Parameter LATENCY, default 2, wait cycles between request capture and response (0..15).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  initiator request strobe, held high until ready is seen.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; word index = addr[DEPTH_LOG2+1:2].
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  read data; valid only while ready = 1.
REQ-010 ready  output  1  one-cycle response pulse ending the transaction.
REQ-011 err  output  1  misaligned-access flag, valid only while ready = 1.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-013 IDLE with req = 1 SHALL capture we, addr and wdata, then go to WAIT with the counter loaded to LATENCY-1, or go directly to RESP when LATENCY = 0.
REQ-014 IDLE with req = 0 SHALL stay in IDLE; ready = 0.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reaches 0; total latency from req capture to ready = LATENCY+1 cycles.
REQ-016 RESP SHALL assert ready for exactly one cycle and then return to IDLE unconditionally.
REQ-017 Reads SHALL drive rdata = mem[captured index] during RESP; otherwise rdata = 0.
REQ-018 Writes SHALL update mem[captured index] with captured wdata on the RESP clock edge; rdata = captured wdata during RESP (write-through).
REQ-019 Inputs SHALL be ignored outside IDLE; req dropping during WAIT SHALL NOT abort the transaction.
REQ-020 Address bits above DEPTH_LOG2+1 SHALL be ignored (index wraps); no error is raised.
REQ-021 req still high in the IDLE cycle after RESP SHALL be treated as a new request (back-to-back throughput: one access per LATENCY+2 cycles).
REQ-022 Storage contents SHALL NOT be initialised by reset.

Reset
REQ-023 rst SHALL force state = IDLE, counter = 0, ready = 0, rdata = 0, err = 0, captured registers = 0, immediately and asynchronously.
REQ-024 rst asserted during WAIT or RESP SHALL discard the pending access; a write not yet committed SHALL NOT reach storage.

Configuration
REQ-025 Macro MEM_RESP_ALIGN_CHK_EN: when defined, captured addr[1:0] != 0 SHALL give err = 1 in RESP, suppress the write and force rdata = 0; timing is unchanged.
REQ-026 Without MEM_RESP_ALIGN_CHK_EN, addr[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-027 Reset, then write 0xDEADBEEF to 0x00000010 (LATENCY = 2) -> ready high exactly 3 cycles after req capture; a subsequent read of 0x10 -> rdata = 0xDEADBEEF with ready.
REQ-028 Read of 0x00001010 after writing 0x12345678 to 0x00000010 (DEPTH_LOG2 = 10) -> rdata = 0x12345678 (index wrap).
REQ-029 req held high continuously across two reads -> two single-cycle ready pulses exactly LATENCY+2 cycles apart.
REQ-030 Write 0xAAAA5555 to 0x20; assert rst during WAIT; release; read 0x20 -> rdata = prior contents, not 0xAAAA5555; ready = 0 throughout reset.
REQ-031 With MEM_RESP_ALIGN_CHK_EN, write 0x11111111 to 0x22 -> err = 1, rdata = 0 with ready; read 0x20 -> contents unchanged, err = 0.
REQ-032 LATENCY = 0: read request -> ready on the cycle immediately after capture.
